// File: rtl/bf_scale_skid.sv
// bf_scale_skid: rounds or saturates radix-2 butterfly outputs back to NBITS bits
// behind a valid/ready register stage with a one-entry skid buffer.
module bf_scale_skid #(
    parameter int NBITS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*NBITS+1:0] in_up,
    input  logic [2*NBITS+1:0] in_down,
    input  logic               shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*NBITS-1:0] out_up,
    output logic [2*NBITS-1:0] out_down,
    output logic               ovf,
    input  logic               ovf_clr
);
    localparam int W = NBITS + 1;

    // Returns {clamped, value}; the add is one bit wider so x=max does not wrap before halving.
    function automatic logic [NBITS:0] scale(input logic [NBITS:0] x, input logic sh);
        logic [NBITS+1:0] r;
        logic [NBITS:0]   t;
        r = {x[NBITS], x} + {{(NBITS+1){1'b0}}, 1'b1};
        t = sh ? r[NBITS+1:1] : x;
        return (t[NBITS] != t[NBITS-1]) ? {1'b1, t[NBITS], {(NBITS-1){!t[NBITS]}}}
                                        : {1'b0, t[NBITS-1:0]};
    endfunction

    logic [4*W-1:0]     in_all;
    logic [4*NBITS-1:0] res;
    logic [3:0]         clamp;
    logic [2*NBITS-1:0] up_s, dn_s;
    logic               accept, load_out;

    logic [2*NBITS-1:0] out_up_q, out_up_d, out_dn_q, out_dn_d;
    logic [2*NBITS-1:0] skid_up_q, skid_up_d, skid_dn_q, skid_dn_d;
    logic               out_valid_q, out_valid_d, skid_full_q, skid_full_d, ovf_q, ovf_d;

    assign in_all = {in_up, in_down};

    always_comb begin
        res   = '0;
        clamp = '0;
        for (int k = 0; k < 4; k++) begin
            {clamp[k], res[k*NBITS +: NBITS]} = scale(in_all[k*W +: W], shift);
        end
        {up_s, dn_s} = res;
    end

    assign accept   = in_valid && !skid_full_q;
    assign load_out = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_up_d    = out_up_q;
        out_dn_d    = out_dn_q;
        skid_full_d = skid_full_q;
        skid_up_d   = skid_up_q;
        skid_dn_d   = skid_dn_q;
        if (load_out) begin
            out_valid_d = skid_full_q || accept;
            out_up_d    = skid_full_q ? skid_up_q : accept ? up_s : out_up_q;
            out_dn_d    = skid_full_q ? skid_dn_q : accept ? dn_s : out_dn_q;
            skid_full_d = 1'b0;
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_up_d   = up_s;
            skid_dn_d   = dn_s;
        end
        ovf_d = (ovf_q && !ovf_clr) || (accept && |clamp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_up_q    <= '0;
            out_dn_q    <= '0;
            skid_full_q <= 1'b0;
            skid_up_q   <= '0;
            skid_dn_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_up_q    <= out_up_d;
            out_dn_q    <= out_dn_d;
            skid_full_q <= skid_full_d;
            skid_up_q   <= skid_up_d;
            skid_dn_q   <= skid_dn_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = !skid_full_q;
    assign out_valid = out_valid_q;
    assign out_up    = out_up_q;
    assign out_down  = out_dn_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_bf_scale_skid.sv
// tb_bf_scale_skid: directed and randomized-handshake checks of bf_scale_skid (NBITS=10)
// against hand-computed values and an integer reference model with a pair queue.
module tb_bf_scale_skid;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, shift, out_valid, out_ready, ovf, ovf_clr;
    logic [21:0] in_up, in_down;
    logic [19:0] out_up, out_down;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [39:0] q[$];
    bit          ovf_m, last_acc;
    int          sent;

    bf_scale_skid #(.NBITS(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_up(in_up), .in_down(in_down), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_up(out_up), .out_down(out_down), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] pk11(input int r, input int i);
        return {r[10:0], i[10:0]};
    endfunction

    function automatic logic [19:0] pk10(input int r, input int i);
        return {r[9:0], i[9:0]};
    endfunction

    // Integer reference: returns {clamped, 10-bit result}.
    function automatic logic [10:0] mcomp(input logic [10:0] xv, input bit sh);
        int x, t;
        bit c;
        x = int'($signed(xv));
        t = sh ? ((x + 1) >>> 1) : x;
        c = 1'b0;
        if (t > 511) begin c = 1'b1; t = 511; end
        else if (t < -512) begin c = 1'b1; t = -512; end
        return {c, t[9:0]};
    endfunction

    task automatic model(output logic [39:0] e, output bit c);
        logic [43:0] a;
        logic [10:0] r;
        a = {in_up, in_down};
        c = 1'b0;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            r = mcomp(a[k*11 +: 11], shift);
            c = c | r[10];
            e[k*10 +: 10] = r[9:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_data();
        in_up   = 22'($urandom);
        in_down = 22'($urandom);
        shift   = 1'($urandom);
    endtask

    task automatic cyc();
        logic [39:0] e;
        bit c, acc, drn;
        c   = 1'b0;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
            chk("out_has_pending", {39'b0, q.size() != 0}, 40'd1);
            if (q.size() != 0) chk("pair_data", {out_up, out_down}, q.pop_front());
        end
        if (acc) begin
            model(e, c);
            q.push_back(e);
        end
        ovf_m = (ovf_m && !ovf_clr) || (acc && c);
        last_acc = acc;
        step();
        chk("ovf", {39'b0, ovf}, {39'b0, ovf_m});
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
        chk(tag, q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; shift = 1'b0; ovf_clr = 1'b0;
        in_up = '0; in_down = '0; ovf_m = 1'b0; last_acc = 1'b0; sent = 0;
        repeat (2) step();
        chk("rst_out_valid", {39'b0, out_valid}, 40'd0);
        chk("rst_in_ready", {39'b0, in_ready}, 40'd1);
        chk("rst_out_up", {20'b0, out_up}, 40'd0);
        chk("rst_out_down", {20'b0, out_down}, 40'd0);
        chk("rst_ovf", {39'b0, ovf}, 40'd0);
        rst = 1'b0;

        // Rounded halving with max/min inputs
        in_valid = 1'b1; shift = 1'b1;
        in_up = pk11(3, -3); in_down = pk11(1023, -1024);
        step();
        chk("t1_out_valid", {39'b0, out_valid}, 40'd1);
        chk("t1_out_up", {20'b0, out_up}, {20'b0, pk10(2, -1)});
        chk("t1_out_down", {20'b0, out_down}, {20'b0, pk10(511, -512)});
        chk("t1_ovf", {39'b0, ovf}, 40'd1);

        // Saturation only
        shift = 1'b0; in_up = pk11(600, -600); in_down = pk11(511, -512);
        step();
        chk("t2_out_up", {20'b0, out_up}, {20'b0, pk10(511, -512)});
        chk("t2_out_down", {20'b0, out_down}, {20'b0, pk10(511, -512)});
        chk("t2_ovf", {39'b0, ovf}, 40'd1);

        ovf_clr = 1'b1; in_up = pk11(5, -7); in_down = pk11(-100, 200);
        step();
        chk("t3_ovf_cleared", {39'b0, ovf}, 40'd0);
        chk("t3_out_up", {20'b0, out_up}, {20'b0, pk10(5, -7)});
        chk("t3_out_down", {20'b0, out_down}, {20'b0, pk10(-100, 200)});

        in_up = pk11(1000, 0); in_down = pk11(0, 0);
        step();
        chk("t4_clr_vs_new_ovf", {39'b0, ovf}, 40'd1);
        chk("t4_out_up", {20'b0, out_up}, {20'b0, pk10(511, 0)});

        in_valid = 1'b0;
        step();
        chk("t5_ovf_cleared", {39'b0, ovf}, 40'd0);
        chk("t5_out_valid", {39'b0, out_valid}, 40'd0);
        ovf_clr = 1'b0;
        ovf_m = 1'b0;

        // Full-throughput stream
        in_valid = 1'b1; out_ready = 1'b1;
        rnd_data();
        for (int i = 0; i < 64; i++) begin
            cyc();
            chk("stream_in_ready", {39'b0, in_ready}, 40'd1);
            chk("stream_out_valid", {39'b0, out_valid}, 40'd1);
            chk("stream_accepted", {39'b0, last_acc}, 40'd1);
            if (last_acc) rnd_data();
        end
        drain("stream_drain");

        // Stall for 3 cycles mid-stream
        in_valid = 1'b1; out_ready = 1'b1;
        rnd_data();
        cyc();
        if (last_acc) rnd_data();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (last_acc) rnd_data();
            chk("stall_in_ready", {39'b0, in_ready}, 40'd0);
            chk("stall_out_valid", {39'b0, out_valid}, 40'd1);
            chk("stall_out_stable", {out_up, out_down}, q[0]);
        end
        chk("stall_held_pairs", q.size(), 2);
        out_ready = 1'b1;
        repeat (6) begin
            cyc();
            if (last_acc) rnd_data();
        end
        drain("stall_drain");

        // Random handshakes against the model
        rnd_data();
        for (int i = 0; i < 5000 && sent < 1000; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            cyc();
            if (last_acc) begin
                sent++;
                rnd_data();
            end
        end
        chk("rand_sent", sent, 1000);
        ovf_clr = 1'b0;
        drain("rand_drain");

        // Reset with both entries occupied
        in_valid = 1'b1; out_ready = 1'b0; shift = 1'b0;
        in_up = pk11(1000, 0); in_down = pk11(0, 0);
        cyc();
        cyc();
        chk("full_before_rst", {39'b0, in_ready}, 40'd0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("rst2_out_valid", {39'b0, out_valid}, 40'd0);
        chk("rst2_in_ready", {39'b0, in_ready}, 40'd1);
        chk("rst2_ovf", {39'b0, ovf}, 40'd0);
        chk("rst2_out_up", {20'b0, out_up}, 40'd0);
        chk("rst2_out_down", {20'b0, out_down}, 40'd0);
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; shift = 1'b1;
        in_up = pk11(-5, 7); in_down = pk11(0, -1024);
        cyc();
        chk("post_rst_out_valid", {39'b0, out_valid}, 40'd1);
        chk("post_rst_out_up", {20'b0, out_up}, {20'b0, pk10(-2, 4)});
        chk("post_rst_out_down", {20'b0, out_down}, {20'b0, pk10(0, -512)});
        drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
